branch_resolve_ctrl: RTL
========================

# branch_resolve_ctrl

Sequencing controller for the execute-stage branch comparator. Accepts one branch/jump instruction at a time from decode over a valid/ready handshake, registers its operands, drives an internal `branch_comp` instance, and computes the target. Taken outcomes produce a one-cycle flush of younger stages and a held redirect to fetch. It also keeps saturating resolution counters for performance monitoring.

## Interface
- `XLEN`, 32: data/address width.
- `CNT_W`, 16: width of the performance counters.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: decode presents an instruction.
- `in_ready` out 1: controller can accept. High only in IDLE.
- `in_kind` in 2: 00 conditional branch, 01 JAL, 10 JALR, 11 reserved.
- `in_op` in 3: funct3 comparator op. 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- `in_pc` in XLEN: instruction PC.
- `in_imm` in XLEN: sign-extended offset.
- `in_rs1`, `in_rs2` in XLEN: forwarded operands.
- `kill` in 1: higher-priority pipeline flush (trap). Cancels in-flight work.
- `redirect_ready` in 1: fetch accepts the redirect.
- `redirect_valid` out 1: redirect request, held until accepted.
- `redirect_pc` out XLEN: new fetch PC, stable while `redirect_valid` is high.
- `flush` out 1: one-cycle pulse that squashes the younger stages.
- `result_valid` out 1: one-cycle pulse when resolution completes.
- `result_taken` out 1: qualified by `result_valid`.
- `result_link` out XLEN: PC+4 for rd writeback of JAL/JALR, qualified by `result_valid`.
- `misalign` out 1: one-cycle pulse when a taken target has bits [1:0] ≠ 0.
- `branch_count`, `taken_count` out CNT_W: saturating counters.

## Operation
- States are IDLE, EVAL and REDIRECT.
- **IDLE:** `in_ready`=1. When `in_valid` is high, capture kind, op, pc, imm, rs1 and rs2, then go to EVAL.
- **EVAL** (always exactly one cycle):
  - `branch_comp` sees the captured rs1, rs2 and op.
  - taken = comparator output for kind 00; 1 for kinds 01 and 10; 0 for kind 11.
  - Target for kinds 00 and 01 is (pc+imm) mod 2^XLEN. Target for kind 10 is ((rs1+imm) mod 2^XLEN) with bit 0 cleared.
  - Every EVAL registers `result_valid`=1, `result_taken`=taken and `result_link`=pc+4 (wraps).
  - Taken with target[1:0]≠0: pulse `misalign`, no flush, no redirect, go to IDLE.
  - Taken with an aligned target: pulse `flush`, load `redirect_pc`, set `redirect_valid`, go to REDIRECT.
  - Not taken: go to IDLE.
- **REDIRECT:** hold `redirect_valid` and `redirect_pc`. Go to IDLE in the cycle `redirect_ready` is high, with `redirect_valid` low from the next cycle.
- **kill:** from any state, return to IDLE next cycle and clear `redirect_valid`.
  - A kill during EVAL suppresses `flush`, `misalign`, the redirect, the counter updates and `result_valid`.
  - `kill` has priority over `in_valid` and `redirect_ready` in the same cycle.
  - A kill in IDLE also blocks capture that cycle.
- **Counters:**
  - `branch_count` increments for every non-killed EVAL with kind 00.
  - `taken_count` increments for every non-killed EVAL that sets `redirect_valid`.
  - Both saturate at all-ones and never wrap.
- Reserved kind 11 resolves as not-taken: `result_valid` pulses and no counter changes.

## Timing
- All outputs are registered except `in_ready`, which is decoded from state.
- Reset value is 0 for every output; state is IDLE.
- Accept on edge N:
  - EVAL occupies cycle N+1.
  - `result_valid`, `flush`, `misalign` and `redirect_valid` are visible in cycle N+2.
- Not-taken and misaligned instructions occupy the block for 2 cycles; `in_ready` returns in N+2.
- Taken instructions hold until `redirect_ready`. If `redirect_ready` is high in N+2, `in_ready` returns in N+3.
- `redirect_ready` without `redirect_valid` is ignored.
- `in_valid` while `in_ready`=0 is not captured; decode holds its data.
- Asserting `rst_n` low mid-operation drops every output to 0 immediately, with no flush pulse.

## Structure
- The shared package `riscv_pkg` holds:
  - the kind encoding constants;
  - the funct3 branch op constants;
  - the state enum typedef;
  - the `XLEN` default.
- One sub-module: the existing `branch_comp` (ports `rs1_data`, `rs2_data`, `branch_op`, `branch_taken`), instantiated on the captured operands.
- The target adders and counters stay inline.

## Test plan
- BEQ, rs1=rs2=10, pc=0x100, imm=0x20 → in N+2: `result_taken`=1, `flush` pulse, `redirect_pc`=0x120. `redirect_ready` held low 3 cycles → `redirect_valid` and PC stable, `in_ready`=0.
- BLT then BGE with rs1=5, rs2=10 → first taken, second `result_taken`=0, no flush. `branch_count`=2, `taken_count`=1.
- BLTU vs BGEU with rs1=0xFFFFFFFF, rs2=1 → BLTU not taken, BGEU taken.
- JALR, rs1=0x1001, imm=0x4, pc=0x200 → `redirect_pc`=0x1004, `result_link`=0x204. JAL with pc=0xFFFFFFFC, imm=8 → `redirect_pc`=0x4 (wrap), `result_link`=0x0.
- BNE taken with imm=0x2 → `misalign` pulse, no flush, no redirect, `in_ready` high in N+2.
- `kill` in the EVAL cycle of a taken BEQ → no flush, no redirect, counters unchanged. `rst_n` low during REDIRECT → `redirect_valid`=0 immediately, IDLE after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared definitions for the execute-stage branch resolution logic:
//   - instruction kind encodings presented by decode
//   - funct3 encodings of the conditional branch comparisons
//   - state type of the resolution controller
//   - default data/address width
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    // Instruction kind (in_kind)
    localparam logic [1:0] KIND_BRANCH = 2'b00;
    localparam logic [1:0] KIND_JAL    = 2'b01;
    localparam logic [1:0] KIND_JALR   = 2'b10;
    localparam logic [1:0] KIND_RSVD   = 2'b11;

    // Conditional branch funct3
    localparam logic [2:0] OP_BEQ  = 3'b000;
    localparam logic [2:0] OP_BNE  = 3'b001;
    localparam logic [2:0] OP_BLT  = 3'b100;
    localparam logic [2:0] OP_BGE  = 3'b101;
    localparam logic [2:0] OP_BLTU = 3'b110;
    localparam logic [2:0] OP_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_EVAL     = 2'b01,
        ST_REDIRECT = 2'b10
    } state_t;

endpackage

// File: rtl/branch_comp.sv
// branch_comp
// Purely combinational branch condition evaluator.
// Ports:
//   rs1_data, rs2_data  in  XLEN  operands
//   branch_op           in  3     funct3 comparison select
//   branch_taken        out 1     comparison result (0 for undefined funct3)
module branch_comp
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [2:0]      branch_op,
    output logic            branch_taken
);

    logic eq;
    logic lt_signed;
    logic lt_unsigned;

    assign eq          = (rs1_data == rs2_data);
    assign lt_signed   = ($signed(rs1_data) < $signed(rs2_data));
    assign lt_unsigned = (rs1_data < rs2_data);

    always_comb begin
        branch_taken = 1'b0;
        case (branch_op)
            OP_BEQ:  branch_taken = eq;
            OP_BNE:  branch_taken = !eq;
            OP_BLT:  branch_taken = lt_signed;
            OP_BGE:  branch_taken = !lt_signed;
            OP_BLTU: branch_taken = lt_unsigned;
            OP_BGEU: branch_taken = !lt_unsigned;
            default: branch_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl
// Execute-stage branch/jump resolution controller. Accepts one instruction
// at a time from decode, evaluates it for exactly one cycle, reports the
// outcome, and for taken aligned targets flushes younger stages and holds a
// redirect to fetch until accepted. Keeps saturating performance counters.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid / in_ready              decode handshake (in_ready = IDLE)
//   in_kind, in_op, in_pc, in_imm,
//   in_rs1, in_rs2                   instruction fields and operands
//   kill                             trap flush, cancels in-flight work
//   redirect_valid / redirect_ready  fetch redirect handshake, redirect_pc
//   flush                            one-cycle squash pulse
//   result_valid, result_taken,
//   result_link                      resolution result (link = pc+4)
//   misalign                         taken target not 4-byte aligned
//   branch_count, taken_count        saturating counters
module branch_resolve_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic             kill,
    input  logic             redirect_ready,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic             result_valid,
    output logic             result_taken,
    output logic [XLEN-1:0]  result_link,
    output logic             misalign,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    state_t           state_reg, state_next;

    // Captured instruction
    logic [1:0]       kind_reg, kind_next;
    logic [2:0]       op_reg, op_next;
    logic [XLEN-1:0]  pc_reg, pc_next;
    logic [XLEN-1:0]  imm_reg, imm_next;
    logic [XLEN-1:0]  rs1_reg, rs1_next;
    logic [XLEN-1:0]  rs2_reg, rs2_next;

    // Registered outputs
    logic             result_valid_reg, result_valid_next;
    logic             result_taken_reg, result_taken_next;
    logic [XLEN-1:0]  result_link_reg, result_link_next;
    logic             flush_reg, flush_next;
    logic             misalign_reg, misalign_next;
    logic             redirect_valid_reg, redirect_valid_next;
    logic [XLEN-1:0]  redirect_pc_reg, redirect_pc_next;
    logic [CNT_W-1:0] branch_count_reg, branch_count_next;
    logic [CNT_W-1:0] taken_count_reg, taken_count_next;

    // Evaluation of the captured instruction
    logic             cmp_taken;
    logic             eval_taken;
    logic [XLEN-1:0]  eval_target;
    logic [XLEN-1:0]  jalr_sum;
    logic             eval_misaligned;

    branch_comp #(
        .XLEN (XLEN)
    ) u_branch_comp (
        .rs1_data     (rs1_reg),
        .rs2_data     (rs2_reg),
        .branch_op    (op_reg),
        .branch_taken (cmp_taken)
    );

    always_comb begin
        jalr_sum    = rs1_reg + imm_reg;
        eval_target = pc_reg + imm_reg;
        eval_taken  = 1'b0;
        case (kind_reg)
            KIND_BRANCH: eval_taken = cmp_taken;
            KIND_JAL:    eval_taken = 1'b1;
            KIND_JALR: begin
                eval_taken  = 1'b1;
                eval_target = {jalr_sum[XLEN-1:1], 1'b0};
            end
            default:     eval_taken = 1'b0;   // reserved kind resolves not-taken
        endcase
    end

    assign eval_misaligned = (eval_target[1:0] != 2'b00);

    always_comb begin
        state_next          = state_reg;
        kind_next           = kind_reg;
        op_next             = op_reg;
        pc_next             = pc_reg;
        imm_next            = imm_reg;
        rs1_next            = rs1_reg;
        rs2_next            = rs2_reg;
        result_valid_next   = 1'b0;
        result_taken_next   = result_taken_reg;
        result_link_next    = result_link_reg;
        flush_next          = 1'b0;
        misalign_next       = 1'b0;
        redirect_valid_next = redirect_valid_reg;
        redirect_pc_next    = redirect_pc_reg;
        branch_count_next   = branch_count_reg;
        taken_count_next    = taken_count_reg;

        if (kill) begin
            // Trap flush wins over capture, evaluation and redirect acceptance.
            state_next          = ST_IDLE;
            redirect_valid_next = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        kind_next  = in_kind;
                        op_next    = in_op;
                        pc_next    = in_pc;
                        imm_next   = in_imm;
                        rs1_next   = in_rs1;
                        rs2_next   = in_rs2;
                        state_next = ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    result_valid_next = 1'b1;
                    result_taken_next = eval_taken;
                    result_link_next  = pc_reg + XLEN'(4);
                    if (kind_reg == KIND_BRANCH && branch_count_reg != '1)
                        branch_count_next = branch_count_reg + CNT_W'(1);
                    if (eval_taken && eval_misaligned) begin
                        misalign_next = 1'b1;
                        state_next    = ST_IDLE;
                    end else if (eval_taken) begin
                        flush_next          = 1'b1;
                        redirect_valid_next = 1'b1;
                        redirect_pc_next    = eval_target;
                        if (taken_count_reg != '1)
                            taken_count_next = taken_count_reg + CNT_W'(1);
                        state_next = ST_REDIRECT;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        redirect_valid_next = 1'b0;
                        state_next          = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= ST_IDLE;
            kind_reg           <= '0;
            op_reg             <= '0;
            pc_reg             <= '0;
            imm_reg            <= '0;
            rs1_reg            <= '0;
            rs2_reg            <= '0;
            result_valid_reg   <= 1'b0;
            result_taken_reg   <= 1'b0;
            result_link_reg    <= '0;
            flush_reg          <= 1'b0;
            misalign_reg       <= 1'b0;
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= '0;
            branch_count_reg   <= '0;
            taken_count_reg    <= '0;
        end else begin
            state_reg          <= state_next;
            kind_reg           <= kind_next;
            op_reg             <= op_next;
            pc_reg             <= pc_next;
            imm_reg            <= imm_next;
            rs1_reg            <= rs1_next;
            rs2_reg            <= rs2_next;
            result_valid_reg   <= result_valid_next;
            result_taken_reg   <= result_taken_next;
            result_link_reg    <= result_link_next;
            flush_reg          <= flush_next;
            misalign_reg       <= misalign_next;
            redirect_valid_reg <= redirect_valid_next;
            redirect_pc_reg    <= redirect_pc_next;
            branch_count_reg   <= branch_count_next;
            taken_count_reg    <= taken_count_next;
        end
    end

    assign in_ready       = (state_reg == ST_IDLE);
    assign redirect_valid = redirect_valid_reg;
    assign redirect_pc    = redirect_pc_reg;
    assign flush          = flush_reg;
    assign result_valid   = result_valid_reg;
    assign result_taken   = result_taken_reg;
    assign result_link    = result_link_reg;
    assign misalign       = misalign_reg;
    assign branch_count   = branch_count_reg;
    assign taken_count    = taken_count_reg;

endmodule
